matrix_frame_ctrl: RTL and testbench
====================================

# matrix_frame_ctrl

Frame sequencer for the 4x4 byte-matrix datapath. It accepts one matrix frame of N*N samples over a valid/ready stream and writes them into an internal N×N store in raster order while accumulating the frame sum. It then drains the frame to a downstream consumer over a second valid/ready stream. It sits between the sample source and the matrix consumer and owns all row/column sequencing.

## Interface
- DW, 8, sample width in bits
- N, 4, matrix dimension; power of two, N ≥ 2
- SUM_W, DW + 2*log2(N) (12 at defaults), frame-sum width; never overflows
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- in_valid  in  1  source has a sample
- in_data  in  DW  sample value
- in_ready  out  1  controller accepts a sample; high only in LOAD
- out_valid  out  1  drain sample available; high only in DRAIN
- out_data  out  DW  drain sample
- out_ready  in  1  consumer accepts the drain sample
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse when a frame has fully drained
- frame_sum  out  SUM_W  sum of the last completed load; held until the next load completes

## Operation
- States: IDLE, LOAD, DRAIN; encoding in the package.
- IDLE: in_ready=0, out_valid=0. When start=1 and abort=0: clear wr_row, wr_col and the accumulator, then go to LOAD.
- LOAD: in_ready=1. On each accept (in_valid & in_ready):
  - write store[wr_row][wr_col] = in_data
  - acc += in_data, computed at SUM_W width
  - wr_col increments and wraps at N-1; wr_row increments when wr_col == N-1.
- On the N*N-th accept: frame_sum ← final acc, including that sample. Clear the read indices and go to DRAIN.
- DRAIN: out_valid=1 and out_data = store at the current read index (combinational read). Each out_valid & out_ready handshake advances the read index. On the N*N-th handshake go to IDLE and pulse frame_done.
- The drain order is set by the macro in Configuration.
- out_data holds stable while out_valid=1 and out_ready=0.
- abort=1: go to IDLE next cycle. No frame_done. frame_sum is unchanged. Store contents are don't-care. Abort has priority over start and over any handshake in the same cycle; a sample presented in that cycle is not accepted.
- start outside IDLE is ignored and is not queued.

## Timing
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, busy=0, frame_done=0, frame_sum=0. All indices and the accumulator are 0.
- start sampled at cycle T: in_ready=1 and busy=1 from T+1.
- Last input accepted at T: in_ready=0 and out_valid=1 from T+1; frame_sum updates at T+1.
- Minimum frame time is 2*N*N + 1 cycles from start to frame_done (33 at N=4).
- Last output handshake at T: frame_done=1 and busy=0 at T+1 only. A start at T+1 is accepted.
- Reset mid-frame returns all outputs to their reset values immediately.

## Configuration
- MATRIX_TRANSPOSE_EN defined: drain is column-major, giving the transposed matrix (store[0][0], store[1][0], … store[N-1][N-1]).
- MATRIX_TRANSPOSE_EN undefined: drain is raster order, identical to the load order.
- All other behaviour, including frame_sum, is identical in both builds.

## Structure
- Package matrix_pkg holds:
  - state enum (IDLE, LOAD, DRAIN)
  - default DW and N
  - a log2 helper
  - SUM_W derivation.
- Sub-module matrix_store: N×N×DW register file with one synchronous write port (row, col, data, we) and one combinational read port (row, col). No reset on the contents.
- The controller holds the FSM, write/read index counters, accumulator and handshakes.

## Test plan
- Load 0..15 with no stalls, out_ready=1. Expect frame_sum=120 (0x078) and frame_done 33 cycles after start.
  - Transpose build drains 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
  - Raster build drains 0..15.
- Load sixteen 0xFF samples. Expect frame_sum=4080 (0xFF0), with no wrap at 12 bits.
- Randomly toggle in_valid and out_ready over the same 0..15 load. Expect the same order and sum, out_data stable under stall, and exactly one frame_done.
- Assert abort after 7 accepted samples. Expect IDLE next cycle, no frame_done, and frame_sum still equal to the previous frame's value. A new frame then completes correctly.
- Pulse start during LOAD and during DRAIN. Expect no effect on the order, the sum, or the frame_done count.
- Assert rst during DRAIN. Expect all outputs at reset values immediately, then a clean frame after rst deasserts.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix frame datapath.
// The drain order is selected by the MATRIX_TRANSPOSE_EN macro in matrix_frame_ctrl.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_N  = 4;

  // Smallest r with 2**r >= value; exact for the power-of-two dimensions used here.
  function automatic int log2_f(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Summing N*N samples of DW bits needs 2*log2(N) extra bits to never overflow.
  function automatic int sum_width(input int dw, input int n);
    return dw + 2 * log2_f(n);
  endfunction

  localparam int DEFAULT_SUM_W = sum_width(DEFAULT_DW, DEFAULT_N);

endpackage

// File: rtl/matrix_store.sv
// N x N register file: one synchronous write port, one combinational read port.
module matrix_store
  import matrix_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int N     = DEFAULT_N,
  parameter int IDX_W = log2_f(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [IDX_W-1:0] wr_col,
  input  logic [DW-1:0]    wr_data,
  input  logic [IDX_W-1:0] rd_row,
  input  logic [IDX_W-1:0] rd_col,
  output logic [DW-1:0]    rd_data
);

  logic [DW-1:0] mem_q [N][N];

  // NOTE: storage has no reset; every entry is written before it is read in a frame.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_row][wr_col] <= wr_data;
  end

  assign rd_data = mem_q[rd_row][rd_col];

endmodule

// File: rtl/matrix_frame_ctrl.sv
// Frame sequencer: loads an N x N frame in raster order, sums it, then drains it.
// Define MATRIX_TRANSPOSE_EN to drain column-major (transposed); default is raster order.
module matrix_frame_ctrl
  import matrix_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int N     = DEFAULT_N,
  parameter int SUM_W = sum_width(DW, N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_done,
  output logic [SUM_W-1:0] frame_sum
);

  localparam int               IDX_W    = log2_f(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [IDX_W-1:0] rd_inner_q, rd_inner_d, rd_outer_q, rd_outer_d;
  logic [SUM_W-1:0] acc_q, acc_d, frame_sum_q, frame_sum_d, acc_next;
  logic             frame_done_q, frame_done_d;
  logic             in_fire, out_fire, wr_last, rd_last;
  logic [IDX_W-1:0] rd_row, rd_col;
  logic [DW-1:0]    rd_data;

  assign in_ready   = (state_q == ST_LOAD);
  assign out_valid  = (state_q == ST_DRAIN);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign frame_sum  = frame_sum_q;
  assign out_data   = out_valid ? rd_data : '0;

  // Abort wins over any handshake in the same cycle.
  assign in_fire  = in_valid & in_ready & ~abort;
  assign out_fire = out_valid & out_ready & ~abort;
  assign wr_last  = (wr_row_q == IDX_LAST) && (wr_col_q == IDX_LAST);
  assign rd_last  = (rd_inner_q == IDX_LAST) && (rd_outer_q == IDX_LAST);
  assign acc_next = acc_q + SUM_W'(in_data);

  // The inner read counter steps fastest; which axis it walks sets the drain order.
`ifdef MATRIX_TRANSPOSE_EN
  assign rd_row = rd_inner_q;
  assign rd_col = rd_outer_q;
`else
  assign rd_row = rd_outer_q;
  assign rd_col = rd_inner_q;
`endif

  matrix_store #(
    .DW    (DW),
    .N     (N),
    .IDX_W (IDX_W)
  ) u_store (
    .clk     (clk),
    .we      (in_fire),
    .wr_row  (wr_row_q),
    .wr_col  (wr_col_q),
    .wr_data (in_data),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_d      = state_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    rd_inner_d   = rd_inner_q;
    rd_outer_d   = rd_outer_q;
    acc_d        = acc_q;
    frame_sum_d  = frame_sum_q;
    frame_done_d = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            wr_row_d = '0;
            wr_col_d = '0;
            acc_d    = '0;
            state_d  = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_fire) begin
            acc_d    = acc_next;
            wr_col_d = (wr_col_q == IDX_LAST) ? '0 : wr_col_q + IDX_ONE;
            if (wr_col_q == IDX_LAST) wr_row_d = wr_row_q + IDX_ONE;
            if (wr_last) begin
              frame_sum_d = acc_next;
              rd_inner_d  = '0;
              rd_outer_d  = '0;
              state_d     = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            rd_inner_d = (rd_inner_q == IDX_LAST) ? '0 : rd_inner_q + IDX_ONE;
            if (rd_inner_q == IDX_LAST) rd_outer_d = rd_outer_q + IDX_ONE;
            if (rd_last) begin
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      rd_inner_q   <= '0;
      rd_outer_q   <= '0;
      acc_q        <= '0;
      frame_sum_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      rd_inner_q   <= rd_inner_d;
      rd_outer_q   <= rd_outer_d;
      acc_q        <= acc_d;
      frame_sum_q  <= frame_sum_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_matrix_frame_ctrl.sv
// Directed bench for matrix_frame_ctrl: drain order and frame sum via a scoreboard queue.
module tb_matrix_frame_ctrl;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int SUM_W = 12;
  localparam int NN    = N * N;

  logic             clk = 1'b0;
  logic             rst, start, abort, in_valid, out_ready;
  logic [DW-1:0]    in_data;
  logic             in_ready, out_valid, busy, frame_done;
  logic [DW-1:0]    out_data;
  logic [SUM_W-1:0] frame_sum;

  matrix_frame_ctrl #(.DW(DW), .N(N), .SUM_W(SUM_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_sum  (frame_sum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) done_cnt <= done_cnt + 1;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] frame_buf [NN];
  logic [DW-1:0] sb_q [$];
  int            exp_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ramp 0..15, 1: all 0xFF, 2: random bytes
  task automatic set_frame(input int mode);
    exp_sum = 0;
    for (int i = 0; i < NN; i++) begin
      case (mode)
        0:       frame_buf[i] = DW'(i);
        1:       frame_buf[i] = 8'hFF;
        default: frame_buf[i] = DW'($urandom);
      endcase
      exp_sum += int'(frame_buf[i]);
    end
  endtask

  task automatic push_expected();
`ifdef MATRIX_TRANSPOSE_EN
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++) sb_q.push_back(frame_buf[r*N + c]);
`else
    for (int i = 0; i < NN; i++) sb_q.push_back(frame_buf[i]);
`endif
  endtask

  task automatic start_frame(output int c0);
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_ready", in_ready, 1);
    check("start_busy", busy, 1);
    check("start_no_done", frame_done, 0);
  endtask

  task automatic load_frame(input bit stall, input bit poke_start);
    int  idx;
    int  guard;
    bit  hs;
    idx = 0;
    guard = 0;
    while (idx < NN && guard < 400) begin
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? frame_buf[idx] : DW'($urandom);
      start    = poke_start && (idx == 5);
      hs       = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("load_count", idx, NN);
    check("load_end_in_ready", in_ready, 0);
    check("load_end_out_valid", out_valid, 1);
    check("frame_sum", frame_sum, exp_sum);
    push_expected();
  endtask

  task automatic drain_frame(input bit stall, input bit poke_start, input int stop_after);
    int n;
    int guard;
    bit hs;
    n = 0;
    guard = 0;
    while (sb_q.size() > 0 && guard < 400 && n != stop_after) begin
      check("drain_out_valid", out_valid, 1);
      check("drain_out_data", out_data, sb_q[0]);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke_start && (n == 3);
      hs        = out_ready && out_valid;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs) begin
        void'(sb_q.pop_front());
        n++;
      end
      guard++;
    end
    out_ready = 1'b0;
    if (stop_after < 0) check("drain_left", sb_q.size(), 0);
  endtask

  // Called in the cycle after the last drain handshake.
  task automatic finish_frame(input int c0, input int d0, input bit check_lat);
    check("frame_done_pulse", frame_done, 1);
    check("done_busy", busy, 0);
    check("done_out_valid", out_valid, 0);
    if (check_lat) check("frame_latency", cyc - c0, 2*NN + 1);
    @(negedge clk); #1;
    check("done_count", done_cnt - d0, 1);
  endtask

  int c0, d0, prev_sum;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_sum", frame_sum, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Ramp frame, no stalls: sum 120, 33-cycle frame.
    set_frame(0);
    d0 = done_cnt;
    start_frame(c0);
    load_frame(1'b0, 1'b0);
    check("ramp_sum", frame_sum, 120);
    drain_frame(1'b0, 1'b0, -1);
    finish_frame(c0, d0, 1'b1);

    // All 0xFF started the cycle right after frame_done: sum 0xFF0 with no wrap.
    set_frame(1);
    d0 = done_cnt;
    start_frame(c0);
    load_frame(1'b0, 1'b0);
    check("ff_sum", frame_sum, 12'hFF0);
    drain_frame(1'b0, 1'b0, -1);
    finish_frame(c0, d0, 1'b1);

    // Ramp with random in_valid / out_ready stalls.
    @(posedge clk); #1;
    set_frame(0);
    d0 = done_cnt;
    start_frame(c0);
    load_frame(1'b1, 1'b0);
    drain_frame(1'b1, 1'b0, -1);
    finish_frame(c0, d0, 1'b0);

    // Random data with start pulses during LOAD and DRAIN.
    @(posedge clk); #1;
    set_frame(2);
    d0 = done_cnt;
    start_frame(c0);
    load_frame(1'b0, 1'b1);
    drain_frame(1'b0, 1'b1, -1);
    finish_frame(c0, d0, 1'b1);
    prev_sum = exp_sum;

    // Abort after 7 accepted samples; the sample offered with abort is dropped.
    @(posedge clk); #1;
    set_frame(0);
    d0 = done_cnt;
    start_frame(c0);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = frame_buf[i];
      @(posedge clk); #1;
    end
    abort    = 1'b1;
    in_data  = frame_buf[7];
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_sum_kept", frame_sum, prev_sum);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_out_valid", out_valid, 0);

    set_frame(0);
    d0 = done_cnt;
    start_frame(c0);
    load_frame(1'b0, 1'b0);
    drain_frame(1'b0, 1'b0, -1);
    finish_frame(c0, d0, 1'b1);

    // Reset during DRAIN: outputs return to reset values without a clock edge.
    @(posedge clk); #1;
    set_frame(1);
    start_frame(c0);
    load_frame(1'b0, 1'b0);
    drain_frame(1'b0, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_frame_sum", frame_sum, 0);
    check("mid_rst_frame_done", frame_done, 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    set_frame(2);
    d0 = done_cnt;
    start_frame(c0);
    load_frame(1'b0, 1'b0);
    drain_frame(1'b0, 1'b0, -1);
    finish_frame(c0, d0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
